// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, sender FSM state encoding and frame-bit helper.
package ps2_pkg;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    StIdle,
    StBitHi,
    StBitLo,
    StGap
  } state_e;

  // Cell idx of a frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic [3:0] sel;
    sel = idx - 4'd1;
    if (idx == 4'd0) begin
      return 1'b0;
    end else if (idx <= 4'd8) begin
      return data[sel[2:0]];
    end else if (idx == 4'd9) begin
      return ~^data;
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/digit_to_scan_code.sv
// Decimal digit to PS/2 set-2 make code; valid_o is low for digits 10..15.
module digit_to_scan_code
  import ps2_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] code_o,
  output logic       valid_o
);

  always_comb begin
    code_o  = 8'h00;
    valid_o = 1'b1;
    unique case (digit_i)
      4'd0:    code_o = SC_0;
      4'd1:    code_o = SC_1;
      4'd2:    code_o = SC_2;
      4'd3:    code_o = SC_3;
      4'd4:    code_o = SC_4;
      4'd5:    code_o = SC_5;
      4'd6:    code_o = SC_6;
      4'd7:    code_o = SC_7;
      4'd8:    code_o = SC_8;
      4'd9:    code_o = SC_9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_digit_sender.sv
// Device-side PS/2 emulator: sends make, F0, make for one decimal digit.
module ps2_digit_sender
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4000,
  parameter int unsigned GAP_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       valid_in,
  input  logic       inhibit_in,
  output logic       ready_out,
  output logic       done_out,
  output logic       err_out,
  output logic       ps2_clk_out,
  output logic       ps2_data_out
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [3:0]      LastBit = 4'(PS2_FRAME_BITS - 1);

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [3:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [7:0]      code_q, code_d;
  logic            clk_q, clk_d;
  logic            data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [7:0] dig_code;
  logic       dig_valid;
  logic [7:0] cur_byte;

  digit_to_scan_code u_map (
    .digit_i (digit_in),
    .code_o  (dig_code),
    .valid_o (dig_valid)
  );

  assign ready_out    = (state_q == StIdle) && !inhibit_in;
  assign done_out     = done_q;
  assign err_out      = err_q;
  assign ps2_clk_out  = clk_q;
  assign ps2_data_out = data_q;

  assign cur_byte = (byte_q == 2'd1) ? SC_BREAK : code_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    code_d  = code_q;
    clk_d   = clk_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_in && ready_out) begin
          if (dig_valid) begin
            code_d  = dig_code;
            byte_d  = 2'd0;
            bit_d   = 4'd0;
            div_d   = '0;
            clk_d   = 1'b1;
            data_d  = frame_bit(dig_code, 4'd0);
            state_d = StBitHi;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StBitHi: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          clk_d   = 1'b0;
          state_d = StBitLo;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StBitLo: begin
        if (div_q == DivLast) begin
          div_d = '0;
          clk_d = 1'b1;
          if (bit_q == LastBit) begin
            gap_d   = '0;
            data_d  = 1'b1;
            state_d = StGap;
          end else begin
            bit_d   = bit_q + 4'd1;
            data_d  = frame_bit(cur_byte, bit_q + 4'd1);
            state_d = StBitHi;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          if (byte_q == 2'd2) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            // Every frame opens with a 0 start bit, whatever the byte.
            byte_d  = byte_q + 2'd1;
            bit_d   = 4'd0;
            div_d   = '0;
            data_d  = 1'b0;
            state_d = StBitHi;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      code_q  <= 8'h00;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      code_q  <= code_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/ps2_digit_sender.md
Name: ps2_digit_sender

Overview:
- Device-side PS/2 keyboard emulator: takes a 4-bit decimal digit and emits the matching key press/release on a PS/2 clock/data pair.
- Sends three 11-bit frames: make code, break prefix 0xF0, make code.
- Drives the lab's PS/2 receive path in simulation and on-board loopback; the inverse of the scan-code-to-binary decode.

Parameters:
- CLK_DIV, 4000, system clocks per PS/2 clock half-period (100 MHz → 12.5 kHz PS/2 clock).
- GAP_CYCLES, 50000, idle clocks (clk=1, data=1) after every frame, before the next frame or completion.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- digit_in  in  4  digit to send; 0..9 valid.
- valid_in  in  1  request; accepted when valid_in && ready_out.
- inhibit_in  in  1  host inhibit (already synchronous); when 1, no new request is accepted.
- ready_out  out  1  idle and not inhibited.
- done_out  out  1  one-cycle pulse when the full sequence has finished.
- err_out  out  1  one-cycle pulse when an invalid digit is offered.
- ps2_clk_out  out  1  PS/2 clock, idle 1.
- ps2_data_out  out  1  PS/2 data, idle 1.

Behaviour:
- Reset values: ready_out=1 (subject to inhibit_in), done_out=0, err_out=0, ps2_clk_out=1, ps2_data_out=1. State is IDLE.
- ready_out is combinational: (state==IDLE) && !inhibit_in. All other outputs are registered.
- Digit map: 0→45, 1→16, 2→1E, 3→26, 4→25, 5→2E, 6→36, 7→3D, 8→3E, 9→46 (hex).
- Invalid digit (10..15) with valid_in && ready_out:
  - err_out pulses on the next cycle.
  - State stays IDLE, lines stay idle, nothing is latched.
- Valid accept at edge N:
  - Digit code is latched and the byte index is set to 0.
  - Frame starts at N+1.
- Frame format: start bit 0, then 8 data bits LSB first, then odd parity (data ones + parity = odd), then stop bit 1. Eleven bit cells in total.
- Bit cell = 2*CLK_DIV cycles:
  - ps2_data_out changes only on the first cycle of a cell.
  - ps2_clk_out is 1 for the first CLK_DIV cycles and 0 for the last CLK_DIV cycles.
  - Receiver samples on the falling edge.
- Bit k of byte b starts at N+1 + b*(22*CLK_DIV+GAP_CYCLES) + 2k*CLK_DIV.
- After the stop cell: GAP_CYCLES with ps2_clk_out=1 and ps2_data_out=1.
- Byte order: index 0 = code, 1 = F0, 2 = code.
- States and transitions:
  - IDLE → BIT_HI on valid accept.
  - BIT_HI → BIT_LO after CLK_DIV cycles.
  - BIT_LO → BIT_HI (next bit) or → GAP after bit 10.
  - GAP → BIT_HI (next byte) or → IDLE after byte 2.
- On entry to IDLE after byte 2, done_out=1 for one cycle and ready_out is high in that same cycle. With CLK_DIV=4 and GAP_CYCLES=10, done_out is high at N+295.
- valid_in while busy is ignored (ready_out=0), with no err_out pulse.
- inhibit_in mid-sequence has no effect; the sequence completes.
- A request held continuously is re-accepted on the done cycle, so back-to-back sequences are allowed.
- rst mid-operation: at the next edge the lines go to 1/1 and state goes to IDLE. The partial frame is abandoned and no done_out pulses.
- Counter widths: $clog2 of CLK_DIV and GAP_CYCLES, plus a 4-bit bit index and a 2-bit byte index.

Decomposition:
- Package ps2_pkg holds:
  - scan-code constants SC_0..SC_9;
  - SC_BREAK = 8'hF0;
  - PS2_FRAME_BITS = 11;
  - the state enum.
- One combinational sub-module, digit_to_scan_code: 4-bit in, 8-bit code out, plus a valid flag. All sequencing stays in the top module.

Test Plan (CLK_DIV=4, GAP_CYCLES=10):
- Send digit 7 → three frames 3D, F0, 3D.
  - Bits sampled at each ps2_clk falling edge: 0,10111100,0,1 then 0,00001111,1,1 then 0,10111100,0,1.
  - done_out high at N+295.
- Send digit 0 → code 45 with parity 0.
- Send digit 12 → err_out=1 for exactly one cycle, lines stay 1/1, ready_out stays 1, done_out never pulses.
- Hold valid_in=1 with digit 3 for two sequences → second start bit at the cycle after the done cycle; frames 26, F0, 26 twice; no idle gap beyond GAP_CYCLES.
- Assert rst during bit 4 of the F0 frame → next cycle lines are 1/1 and ready_out=1; no done_out pulse; a new digit 1 then sends 16, F0, 16 correctly.
- Raise inhibit_in in IDLE with valid_in=1 → ready_out=0 and no transmission. Release inhibit_in → accepted on that edge.
